// File: rtl/audio_pkg.sv
// Shared types and defaults for the audio ADC receiver: capture FSM states and the stereo frame.
package audio_pkg;

  localparam int unsigned DefaultDataWidth = 16;

  typedef enum logic [1:0] {
    StWaitSync,
    StSkip,
    StShift,
    StHold
  } capture_state_e;

  typedef struct packed {
    logic [DefaultDataWidth-1:0] left;
    logic [DefaultDataWidth-1:0] right;
  } stereo_frame_t;

endpackage

// File: rtl/audio_rx_fifo.sv
// First-word-fall-through frame buffer with count/full/empty, simultaneous push/pop and a
// sticky overflow flag.
module audio_rx_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     clear_overflow_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     overflow_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             overflow_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o    = (count_q == '0);
    full_o     = (count_q == CntW'(Depth));
    do_pop     = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
    do_push    = push_i & (~full_o | do_pop);
    rdata_o    = empty_o ? '0 : mem_q[rd_ptr_q];
    count_o    = count_q;
    overflow_o = overflow_q;
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
      if (push_i && !do_push) begin
        overflow_q <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/audio_adc_receiver.sv
// I2S ADC capture into a stereo frame FIFO, all in the clk domain.
// Define AUDIO_ADC_MONO_MIX_EN to push the averaged (L+R)/2 sample into both channels.
module audio_adc_receiver
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_ADCLRCK,
  input  logic                          AUD_ADCDAT,
  input  logic                          rd_en,
  input  logic                          clear_overflow,
  output logic [DATA_WIDTH-1:0]         rd_left,
  output logic [DATA_WIDTH-1:0]         rd_right,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

  logic [1:0] bclk_sync_q, lrck_sync_q, dat_sync_q;
  logic       bclk_prev_q, lrck_prev_q;
  logic       bclk_s, lrck_s, dat_s, bclk_rise, lrck_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      bclk_sync_q <= '0;
      lrck_sync_q <= '0;
      dat_sync_q  <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], AUD_BCLK};
      lrck_sync_q <= {lrck_sync_q[0], AUD_ADCLRCK};
      dat_sync_q  <= {dat_sync_q[0], AUD_ADCDAT};
      bclk_prev_q <= bclk_sync_q[1];
      lrck_prev_q <= lrck_sync_q[1];
    end
  end

  assign bclk_s    = bclk_sync_q[1];
  assign lrck_s    = lrck_sync_q[1];
  assign dat_s     = dat_sync_q[1];
  assign bclk_rise = bclk_s & ~bclk_prev_q;
  assign lrck_edge = lrck_s ^ lrck_prev_q;

  capture_state_e        state_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q, shift_next, left_q;
  logic [DATA_WIDTH-1:0] push_left_q, push_right_q;
  logic                  chan_q, left_valid_q, push_q;

  assign shift_next = {shift_q[DATA_WIDTH-2:0], dat_s};

`ifdef AUDIO_ADC_MONO_MIX_EN
  logic [DATA_WIDTH:0] mix_sum;
  assign mix_sum = {left_q[DATA_WIDTH-1], left_q} + {shift_next[DATA_WIDTH-1], shift_next};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitSync;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_q       <= '0;
      chan_q       <= 1'b0;
      left_valid_q <= 1'b0;
      push_q       <= 1'b0;
      push_left_q  <= '0;
      push_right_q <= '0;
    end else begin
      push_q <= 1'b0;
      if (lrck_edge) begin
        state_q   <= StSkip;
        chan_q    <= lrck_s;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        // A new left word starts a new frame; an edge mid-word abandons the frame in flight.
        if (state_q == StShift || !lrck_s) left_valid_q <= 1'b0;
      end else if (bclk_rise) begin
        case (state_q)
          StSkip: state_q <= StShift;
          StShift: begin
            shift_q   <= shift_next;
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
              state_q <= StHold;
              if (!chan_q) begin
                left_q       <= shift_next;
                left_valid_q <= 1'b1;
              end else if (left_valid_q) begin
                push_q       <= 1'b1;
                left_valid_q <= 1'b0;
`ifdef AUDIO_ADC_MONO_MIX_EN
                push_left_q  <= mix_sum[DATA_WIDTH:1];
                push_right_q <= mix_sum[DATA_WIDTH:1];
`else
                push_left_q  <= left_q;
                push_right_q <= shift_next;
`endif
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [2*DATA_WIDTH-1:0] rd_frame;

  audio_rx_fifo #(
    .Width (2 * DATA_WIDTH),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i            (clk),
    .reset_i          (reset),
    .push_i           (push_q),
    .wdata_i          ({push_left_q, push_right_q}),
    .pop_i            (rd_en),
    .clear_overflow_i (clear_overflow),
    .rdata_o          (rd_frame),
    .empty_o          (fifo_empty),
    .full_o           (fifo_full),
    .count_o          (fifo_count),
    .overflow_o       (overflow)
  );

  assign rd_left  = rd_frame[2*DATA_WIDTH-1:DATA_WIDTH];
  assign rd_right = rd_frame[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Self-checking bench: drives I2S frames at ~3.07 MHz BCLK against a queue-based frame model.
module tb_audio_adc_receiver;
  import audio_pkg::*;

  localparam int unsigned Depth = 8;
  // clk period 40 units; BCLK half period 326 units (ratio ~16.3, i.e. 50 MHz vs 3.07 MHz).
  // BCLK edges land on odd times, clk edges on even times, so they never coincide.
  localparam int unsigned BclkHalf = 326;

  logic        clk = 1'b0;
  logic        reset, AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT, rd_en, clear_overflow;
  logic [15:0] rd_left, rd_right;
  logic        fifo_empty, fifo_full, overflow;
  logic [3:0]  fifo_count;

  int            checks = 0;
  int            errors = 0;
  stereo_frame_t model_q[$];
  logic          model_ovf;
  event          final_bit_ev;

  always #20 clk = ~clk;

  audio_adc_receiver #(
    .DATA_WIDTH (16),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .AUD_BCLK       (AUD_BCLK),
    .AUD_ADCLRCK    (AUD_ADCLRCK),
    .AUD_ADCDAT     (AUD_ADCDAT),
    .rd_en          (rd_en),
    .clear_overflow (clear_overflow),
    .rd_left        (rd_left),
    .rd_right       (rd_right),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  initial begin
    #(40 * 90000);
    $display("FAIL watchdog: observed no finish, required finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic stereo_frame_t expect_frame(input logic [15:0] l, input logic [15:0] r);
    stereo_frame_t f;
`ifdef AUDIO_ADC_MONO_MIX_EN
    int a, b, m;
    a = $signed(l);
    b = $signed(r);
    m = (a + b) >>> 1;
    f.left  = m[15:0];
    f.right = m[15:0];
`else
    f.left  = l;
    f.right = r;
`endif
    return f;
  endfunction

  task automatic model_push(input logic [15:0] l, input logic [15:0] r);
    if (model_q.size() < Depth) model_q.push_back(expect_frame(l, r));
    else model_ovf = 1'b1;
  endtask

  task automatic check_status(input string tag);
    @(negedge clk);
    check({tag, ".count"}, 32'(fifo_count), 32'(model_q.size()));
    check({tag, ".empty"}, 32'(fifo_empty), 32'(model_q.size() == 0));
    check({tag, ".full"}, 32'(fifo_full), 32'(model_q.size() == Depth));
    check({tag, ".ovf"}, 32'(overflow), 32'(model_ovf));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".count"}, 32'(fifo_count), 32'd0);
    check({tag, ".empty"}, 32'(fifo_empty), 32'd1);
    check({tag, ".full"}, 32'(fifo_full), 32'd0);
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
    check({tag, ".left"}, 32'(rd_left), 32'd0);
    check({tag, ".right"}, 32'(rd_right), 32'd0);
  endtask

  task automatic read_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check({tag, ".nonempty"}, 32'(fifo_empty), 32'd0);
      check({tag, ".left"}, 32'(rd_left), 32'(model_q[0].left));
      check({tag, ".right"}, 32'(rd_right), 32'(model_q[0].right));
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      void'(model_q.pop_front());
    end
    check_status({tag, ".after"});
  endtask

  task automatic idle_bclk(input int n);
    @(negedge clk);
    #7;
    repeat (n) begin
      AUD_BCLK = 1'b0;
      #BclkHalf;
      AUD_BCLK = 1'b1;
      #BclkHalf;
    end
  endtask

  // One I2S frame: left word while LRCK low, right word while LRCK high, one-bit delay, MSB first.
  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input int left_len = 32, input int right_len = 32,
                            input bit mark = 1'b0);
    int          len;
    logic [15:0] w;
    @(negedge clk);
    #7;
    for (int ch = 0; ch < 2; ch++) begin
      len = (ch == 0) ? left_len : right_len;
      w   = (ch == 0) ? l : r;
      for (int i = 0; i < len; i++) begin
        AUD_BCLK = 1'b0;
        if (i == 0) AUD_ADCLRCK = (ch == 1);
        AUD_ADCDAT = (i >= 1 && i <= 16) ? w[16-i] : 1'($urandom_range(0, 1));
        #BclkHalf;
        AUD_BCLK = 1'b1;
        if (mark && ch == 1 && i == 16) -> final_bit_ev;
        #BclkHalf;
      end
    end
  endtask

  task automatic send_good(input logic [15:0] l, input logic [15:0] r);
    send_frame(l, r);
    model_push(l, r);
  endtask

  // The frame is written on the 4th clk edge after the final right bit rises (2 sync, 1 edge
  // detect, 1 push register); pulse the chosen control so it is sampled on that same edge.
  task automatic pulse_at_push(input bit do_pop, input bit do_clear);
    @(final_bit_ev);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd_en          = do_pop;
    clear_overflow = do_clear;
    @(negedge clk);
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
  endtask

  initial begin
    logic [15:0] l, r;
    reset          = 1'b1;
    AUD_BCLK       = 1'b0;
    AUD_ADCLRCK    = 1'b1;
    AUD_ADCDAT     = 1'b0;
    rd_en          = 1'b0;
    clear_overflow = 1'b0;
    model_ovf      = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Read while empty is ignored.
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    check_status("rd_empty");
    idle_bclk(4);

    // Basic frame.
    send_good(16'h8001, 16'h7FFE);
    check_status("basic");
    read_check("basic", 1);

    // Random frames.
    for (int k = 0; k < 3; k++) send_good(16'($urandom()), 16'($urandom()));
    check_status("rand");
    read_check("rand", 3);

    // LRCK toggles after 10 left bits: frame dropped, next one intact.
    send_frame(16'($urandom()), 16'($urandom()), 11, 32);
    send_good(16'($urandom()), 16'($urandom()));
    check_status("trunc");
    read_check("trunc", 1);

    // Nine frames with no reads; clear_overflow on the drop cycle loses to the set.
    for (int k = 0; k < 8; k++) send_good(16'($urandom()), 16'($urandom()));
    l = 16'($urandom());
    r = 16'($urandom());
    fork
      send_frame(l, r, 32, 32, 1'b1);
      pulse_at_push(1'b0, 1'b1);
    join
    model_push(l, r);
    check_status("ovf");
    read_check("ovf", 8);
    @(negedge clk);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    model_ovf = 1'b0;
    check_status("clr");

    // Full buffer with a pop on the push cycle.
    for (int k = 0; k < 8; k++) send_good(16'($urandom()), 16'($urandom()));
    check_status("full");
    l = 16'($urandom());
    r = 16'($urandom());
    fork
      send_frame(l, r, 32, 32, 1'b1);
      pulse_at_push(1'b1, 1'b0);
    join
    void'(model_q.pop_front());
    model_q.push_back(expect_frame(l, r));
    check_status("pushpop");
    read_check("pushpop", 8);

    // Reset in the middle of a right word.
    send_good(16'($urandom()), 16'($urandom()));
    send_frame(16'($urandom()), 16'($urandom()), 32, 9);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    model_q.delete();
    model_ovf = 1'b0;
    reset = 1'b0;
    idle_bclk(4);
    send_good(16'($urandom()), 16'($urandom()));
    check_status("midrst.after");
    read_check("midrst", 1);

    // Extreme values (averaged when mono mixing is built in).
    send_good(16'h7FFF, 16'h7FFF);
    send_good(16'h8000, 16'h0000);
    check_status("mix");
`ifdef AUDIO_ADC_MONO_MIX_EN
    check("mix.max.left", 32'(rd_left), 32'h7FFF);
    check("mix.max.right", 32'(rd_right), 32'h7FFF);
`endif
    read_check("mix", 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
